// File: rtl/axi_4_lite_req_arbiter_if.sv
// AXI4-Lite master-side bus bundle for the two-requester arbiter.
// Default widths come from the shared C_AXI_* macros when the build does not define them.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH 4
`endif

interface axi_4_lite_req_arbiter_if #(
  parameter int AW = `C_AXI_ADDR_WIDTH,
  parameter int DW = `C_AXI_DATA_WIDTH,
  parameter int SW = `C_AXI_STROBE_WIDTH
) ();
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY;
  logic [AW-1:0] M_AXI_AWADDR;
  logic [2:0]    M_AXI_AWPROT;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY;
  logic [DW-1:0] M_AXI_WDATA;
  logic [SW-1:0] M_AXI_WSTRB;
  logic          M_AXI_BVALID;
  logic          M_AXI_BREADY;
  logic [1:0]    M_AXI_BRESP;
  logic          M_AXI_ARVALID;
  logic          M_AXI_ARREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [2:0]    M_AXI_ARPROT;
  logic          M_AXI_RVALID;
  logic          M_AXI_RREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;

  modport master (
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  modport slave (
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );
endinterface

// File: rtl/axi_4_lite_req_arbiter.sv
// Two-requester round-robin arbiter sequencing single-beat commands onto one
// AXI4-Lite master port; one transaction in flight at a time.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH 4
`endif

module axi_4_lite_req_arbiter #(
  parameter int AW = `C_AXI_ADDR_WIDTH,
  parameter int DW = `C_AXI_DATA_WIDTH,
  parameter int SW = `C_AXI_STROBE_WIDTH
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic [1:0]          REQ_VALID,
  output logic [1:0]          REQ_READY,
  input  logic [1:0]          REQ_WE,
  input  logic [2*AW-1:0]     REQ_ADDR,
  input  logic [2*DW-1:0]     REQ_WDATA,
  input  logic [2*SW-1:0]     REQ_WSTRB,
  output logic [1:0]          RSP_VALID,
  output logic [DW-1:0]       RSP_RDATA,
  output logic [1:0]          RSP_RESP,
  axi_4_lite_req_arbiter_if.master m_axi
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t        state, state_nx;
  logic          last_grant;
  logic          gnt;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          aw_done, w_done;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  logic          sel, grant;
  logic          aw_valid, w_valid, ar_valid;
  logic          aw_hs, w_hs;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_wstrb  <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_resp   <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        gnt        <= sel;
        last_grant <= sel;
        cmd_addr   <= sel ? REQ_ADDR[2*AW-1:AW]  : REQ_ADDR[AW-1:0];
        cmd_wdata  <= sel ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
        cmd_wstrb  <= sel ? REQ_WSTRB[2*SW-1:SW] : REQ_WSTRB[SW-1:0];
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      // AW and W complete independently; each flag masks its VALID afterwards.
      if (state == WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state == WR_RESP && m_axi.M_AXI_BVALID)
        rsp_resp <= m_axi.M_AXI_BRESP;
      if (state == RD_DATA && m_axi.M_AXI_RVALID) begin
        rsp_rdata <= m_axi.M_AXI_RDATA;
        rsp_resp  <= m_axi.M_AXI_RRESP;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    sel       = (REQ_VALID == 2'b11) ? ~last_grant : REQ_VALID[1];
    grant     = (state == IDLE) && S_AXI_ARESETN && (REQ_VALID != 2'b00);
    aw_valid  = (state == WR) && !aw_done;
    w_valid   = (state == WR) && !w_done;
    ar_valid  = (state == RD_ADDR);
    aw_hs     = aw_valid && m_axi.M_AXI_AWREADY;
    w_hs      = w_valid && m_axi.M_AXI_WREADY;
    REQ_READY = '0;
    RSP_VALID = '0;

    if (grant) REQ_READY = sel ? 2'b10 : 2'b01;
    if (state == DONE) RSP_VALID = gnt ? 2'b10 : 2'b01;

    case (state)
      IDLE:    if (grant) state_nx = REQ_WE[sel] ? WR : RD_ADDR;
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_RESP;
      WR_RESP: if (m_axi.M_AXI_BVALID) state_nx = DONE;
      RD_ADDR: if (m_axi.M_AXI_ARREADY) state_nx = RD_DATA;
      RD_DATA: if (m_axi.M_AXI_RVALID) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    m_axi.M_AXI_AWVALID = aw_valid;
    m_axi.M_AXI_AWADDR  = cmd_addr;
    m_axi.M_AXI_AWPROT  = 3'b000;
    m_axi.M_AXI_WVALID  = w_valid;
    m_axi.M_AXI_WDATA   = cmd_wdata;
    m_axi.M_AXI_WSTRB   = cmd_wstrb;
    m_axi.M_AXI_BREADY  = (state == WR_RESP);
    m_axi.M_AXI_ARVALID = ar_valid;
    m_axi.M_AXI_ARADDR  = cmd_addr;
    m_axi.M_AXI_ARPROT  = 3'b000;
    m_axi.M_AXI_RREADY  = (state == RD_DATA);
  end

  assign RSP_RDATA = rsp_rdata;
  assign RSP_RESP  = rsp_resp;

endmodule

// File: tb/tb_axi_4_lite_req_arbiter.sv
// Directed bench: a small 4-word AXI4-Lite slave model with per-channel delay
// knobs drives the arbiter; expected values are hand-derived cycle by cycle.
module tb_axi_4_lite_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_we = '0;
  logic [2*AW-1:0]   req_addr = '0;
  logic [2*DW-1:0]   req_wdata = '0;
  logic [2*SW-1:0]   req_wstrb = '0;
  logic [1:0]        rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;

  axi_4_lite_req_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

  axi_4_lite_req_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_WSTRB(req_wstrb),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int unsigned aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 1, r_dly = 1;
  logic        b_hold = 1'b0, r_force = 1'b0;
  logic [31:0] r_fdata = '0;
  logic [1:0]  r_fresp = '0;
  int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_a;
  logic [3:0]  w_s;
  logic [31:0] mem [4];
  logic        s_aw_hs, s_w_hs, s_wr_done;
  logic [31:0] s_wa, s_wd;
  logic [3:0]  s_ws;

  assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_dly);
  assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_cnt >= w_dly);
  assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= ar_dly);
  assign bus.M_AXI_BVALID  = b_pend && (b_cnt == 0) && !b_hold;
  assign bus.M_AXI_BRESP   = 2'b00;
  assign bus.M_AXI_RVALID  = r_pend && (r_cnt == 0);
  assign bus.M_AXI_RDATA   = r_force ? r_fdata : mem[r_a[3:2]];
  assign bus.M_AXI_RRESP   = r_force ? r_fresp : 2'b00;

  assign s_aw_hs   = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
  assign s_w_hs    = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
  assign s_wr_done = (aw_got || s_aw_hs) && (w_got || s_w_hs);
  assign s_wa      = s_aw_hs ? bus.M_AXI_AWADDR : aw_a;
  assign s_wd      = s_w_hs ? bus.M_AXI_WDATA : w_d;
  assign s_ws      = s_w_hs ? bus.M_AXI_WSTRB : w_s;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0; r_a <= '0;
    end else begin
      if (s_aw_hs) begin aw_got <= 1'b1; aw_a <= bus.M_AXI_AWADDR; aw_cnt <= 0; end
      else if (bus.M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (s_w_hs) begin w_got <= 1'b1; w_d <= bus.M_AXI_WDATA; w_s <= bus.M_AXI_WSTRB; w_cnt <= 0; end
      else if (bus.M_AXI_WVALID) w_cnt <= w_cnt + 1;
      if (s_wr_done) begin
        for (int k = 0; k < 4; k++)
          if (s_ws[k]) mem[s_wa[3:2]][8*k +: 8] <= s_wd[8*k +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        b_pend <= 1'b1; b_cnt <= b_dly - 1;
      end else if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_pend <= 1'b0;
      else if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= r_dly - 1; r_a <= bus.M_AXI_ARADDR;
      end else begin
        if (bus.M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;
        if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_pend <= 1'b0;
        else if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      if (rsp_valid != 2'b00) begin seen = 1'b1; break; end
    end
    chk({tag, "_seen"}, {63'd0, seen}, 64'd1);
    chk({tag, "_who"}, {62'd0, rsp_valid}, {62'd0, exp});
  endtask

  task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    req_valid[r]           = 1'b1;
    req_we[r]              = we;
    req_addr[32*r +: 32]   = addr;
    req_wdata[32*r +: 32]  = data;
    req_wstrb[4*r +: 4]    = strb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [1:0] g_val [4];
  int         g_cyc [4];
  logic [1:0] r_val [4];
  int         ng, nr;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
                     bus.M_AXI_RREADY, req_ready, rsp_valid, rsp_resp}, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_addr", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 64'd0);
    chk("rst_wdata", {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, 64'd0);
    chk("rst_prot", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie: both requesters hold writes for four transactions
    @(negedge clk);
    set_req(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF);
    set_req(1, 1'b1, 32'h8, 32'h2222_2222, 4'hF);
    ng = 0; nr = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin g_val[ng] = req_ready; g_cyc[ng] = c; ng++; end
      if (rsp_valid != 2'b00 && nr < 4) begin r_val[nr] = rsp_valid; nr++; end
      if (ng == 4 && nr == 4) break;
      @(negedge clk);
      if (ng == 4) req_valid = 2'b00;
    end
    chk("tie_ngrant", ng, 4);
    chk("tie_nrsp", nr, 4);
    chk("tie_g0", {62'd0, g_val[0]}, 64'd1);
    chk("tie_g1", {62'd0, g_val[1]}, 64'd2);
    chk("tie_g2", {62'd0, g_val[2]}, 64'd1);
    chk("tie_g3", {62'd0, g_val[3]}, 64'd2);
    chk("tie_gcyc1", g_cyc[1], 4);
    chk("tie_gcyc3", g_cyc[3], 12);
    chk("tie_r0", {62'd0, r_val[0]}, 64'd1);
    chk("tie_r1", {62'd0, r_val[1]}, 64'd2);
    chk("tie_r2", {62'd0, r_val[2]}, 64'd1);
    chk("tie_r3", {62'd0, r_val[3]}, 64'd2);

    // Write, requester 0 only, always-ready slave
    @(negedge clk);
    set_req(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("w0_c0_ready", {62'd0, req_ready}, 64'd1);
    nxt(); req_valid = 2'b00;
    chk("w0_c1_awv_wv", {bus.M_AXI_AWVALID, bus.M_AXI_AWREADY, bus.M_AXI_WVALID, bus.M_AXI_WREADY}, 64'hF);
    chk("w0_c1_awaddr", bus.M_AXI_AWADDR, 64'h4);
    chk("w0_c1_wdata", {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, 64'hF_DEAD_BEEF);
    nxt();
    chk("w0_c2_resp", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_BVALID}, 64'h3);
    chk("w0_c2_rspv", {62'd0, rsp_valid}, 64'd0);
    nxt();
    chk("w0_c3_rspv", {62'd0, rsp_valid}, 64'd1);
    chk("w0_c3_resp", {62'd0, rsp_resp}, 64'd0);
    chk("w0_mem", mem[1], 64'hDEAD_BEEF);

    // Write with WREADY held back until cycle 4
    w_dly = 3;
    @(negedge clk);
    set_req(0, 1'b1, 32'hC, 32'hA5A5_A5A5, 4'hF);
    #1;
    chk("ws_c0_ready", {62'd0, req_ready}, 64'd1);
    nxt(); req_valid = 2'b00;
    chk("ws_c1", {bus.M_AXI_AWVALID, bus.M_AXI_AWREADY, bus.M_AXI_WVALID, bus.M_AXI_WREADY}, 64'hE);
    nxt();
    chk("ws_c2", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}, 64'h2);
    nxt();
    chk("ws_c3", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}, 64'h2);
    nxt();
    chk("ws_c4", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WREADY, bus.M_AXI_BREADY}, 64'h6);
    nxt();
    chk("ws_c5", {bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_BVALID}, 64'h3);
    nxt();
    chk("ws_c6_rspv", {62'd0, rsp_valid}, 64'd1);
    chk("ws_mem", mem[3], 64'hA5A5_A5A5);
    w_dly = 0;

    // Read, requester 1, slow AR and R, SLVERR
    ar_dly = 2; r_dly = 3; r_force = 1'b1; r_fdata = 32'h1234_5678; r_fresp = 2'b10;
    @(negedge clk);
    set_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
    #1;
    chk("rd_c0_ready", {62'd0, req_ready}, 64'd2);
    nxt(); req_valid = 2'b00;
    chk("rd_c1", {bus.M_AXI_ARVALID, bus.M_AXI_ARREADY, bus.M_AXI_RREADY}, 64'h4);
    chk("rd_c1_araddr", bus.M_AXI_ARADDR, 64'h8);
    nxt();
    chk("rd_c2", {bus.M_AXI_ARVALID, bus.M_AXI_ARREADY, bus.M_AXI_RREADY}, 64'h4);
    nxt();
    chk("rd_c3", {bus.M_AXI_ARVALID, bus.M_AXI_ARREADY, bus.M_AXI_RREADY}, 64'h6);
    nxt();
    chk("rd_c4", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_RVALID, rsp_valid}, 64'h8);
    nxt();
    chk("rd_c5", {bus.M_AXI_RREADY, bus.M_AXI_RVALID, rsp_valid}, 64'h8);
    nxt();
    chk("rd_c6", {bus.M_AXI_RREADY, bus.M_AXI_RVALID, rsp_valid}, 64'hC);
    nxt();
    chk("rd_c7", {bus.M_AXI_RREADY, rsp_valid}, 64'h2);
    chk("rd_c7_data", {rsp_resp, rsp_rdata}, 64'h2_1234_5678);
    nxt();
    chk("rd_c8", {bus.M_AXI_RREADY, rsp_valid}, 64'h0);
    chk("rd_c8_hold", {rsp_resp, rsp_rdata}, 64'h2_1234_5678);
    ar_dly = 0; r_dly = 1; r_force = 1'b0;

    // Reset during WR_RESP with BVALID withheld
    b_hold = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 32'h4, 32'h0000_0055, 4'hF);
    #1;
    chk("rs_c0_ready", {62'd0, req_ready}, 64'd1);
    nxt(); req_valid = 2'b00;
    nxt();
    chk("rs_c2_bready", {bus.M_AXI_BREADY, bus.M_AXI_BVALID}, 64'h2);
    nxt();
    chk("rs_c3_bready", {bus.M_AXI_BREADY, bus.M_AXI_BVALID}, 64'h2);
    rst_n = 1'b0;
    nxt();
    chk("rs_ctrl", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
                    bus.M_AXI_RREADY, req_ready, rsp_valid, rsp_resp}, 64'd0);
    chk("rs_rdata", rsp_rdata, 64'd0);
    chk("rs_addr", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 64'd0);
    chk("rs_wdata", {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, 64'd0);
    rst_n = 1'b1; b_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("rs_no_rsp", {62'd0, rsp_valid}, 64'd0);
    end
    @(negedge clk);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
    #1;
    chk("rs_r1_ready", {62'd0, req_ready}, 64'd2);
    nxt(); req_valid = 2'b00;
    wait_rsp("rs_r1", 2'b10);
    chk("rs_r1_data", {rsp_resp, rsp_rdata}, 64'h0_0000_0055);
    @(negedge clk);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
    #1;
    chk("rs_tie_ready", {62'd0, req_ready}, 64'd1);
    nxt(); req_valid[0] = 1'b0;
    chk("rs_tie_no1", {62'd0, req_ready}, 64'd0);
    wait_rsp("rs_tie0", 2'b01);
    chk("rs_tie0_data", rsp_rdata, 64'h1111_1111);
    nxt();
    chk("rs_tie1_ready", {62'd0, req_ready}, 64'd2);
    nxt(); req_valid = 2'b00;
    wait_rsp("rs_tie1", 2'b10);
    chk("rs_tie1_data", rsp_rdata, 64'h2222_2222);

    // Requester 1 write then read back-to-back to address 0
    @(negedge clk);
    set_req(1, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
    #1;
    chk("bb_c0_ready", {62'd0, req_ready}, 64'd2);
    nxt();
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("bb_c1_ready", {62'd0, req_ready}, 64'd0);
    nxt();
    chk("bb_c2_ready", {62'd0, req_ready}, 64'd0);
    nxt();
    chk("bb_c3", {req_ready, rsp_valid}, 64'h2);
    nxt();
    chk("bb_c4_ready", {62'd0, req_ready}, 64'd2);
    nxt(); req_valid = 2'b00;
    wait_rsp("bb_rd", 2'b10);
    chk("bb_rd_data", {rsp_resp, rsp_rdata}, 64'h0_CAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
